// File: rtl/add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell, used as the bit-slice of the serial datapath.
module fullAdder (
  input  logic inA,
  input  logic inB,
  input  logic carryIn,
  output logic sum,
  output logic carryOut
);

  assign sum      = inA ^ inB ^ carryIn;
  assign carryOut = (inA & inB) | (carryIn & (inA ^ inB));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a
// single fullAdder slice, with valid/ready request and response handshakes.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             subtract,
  output logic             resValid,
  input  logic             resReady,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;

  fullAdder u_fa (
    .inA      (a_q[0]),
    .inB      (b_q[0]),
    .carryIn  (carry_q),
    .sum      (fa_sum),
    .carryOut (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (startValid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = opA;
          b_d     = opB ^ {WIDTH{subtract == OP_SUB}};
          carry_d = (subtract == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB slice on this last bit.
          co_d    = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign startReady = (state_q == IDLE);
  assign resValid   = (state_q == DONE);
  assign result     = res_q;
  assign carryOut   = co_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed-vector bench for serial_add_sub at WIDTH=8.
module tb_serial_add_sub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         startValid = 1'b0;
  logic         startReady;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         subtract = 1'b0;
  logic         resValid;
  logic         resReady = 1'b0;
  logic [W-1:0] result;
  logic         carryOut;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .startValid (startValid),
    .startReady (startReady),
    .opA        (opA),
    .opB        (opB),
    .subtract   (subtract),
    .resValid   (resValid),
    .resReady   (resReady),
    .result     (result),
    .carryOut   (carryOut),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Present one request, then wait (bounded) for resValid; lat counts edges
  // after the accept edge. Operands are scrambled right after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, output int lat);
    @(negedge clk);
    opA = a; opB = b; subtract = sub; startValid = 1'b1;
    @(posedge clk);
    #1;
    startValid = 1'b0;
    opA = ~a; opB = ~b; subtract = ~sub;
    lat = 0;
    while (!resValid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack_result();
    @(negedge clk);
    resReady = 1'b1;
    @(posedge clk);
    #1;
    resReady = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (startReady !== 1'b1 || resValid !== 1'b0 || result !== 8'h00 ||
        carryOut !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b val=%b res=%h co=%b ov=%b expected 1 0 00 0 0",
               startReady, resValid, result, carryOut, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'h01};
    logic [W-1:0] er [3] = '{8'h10, 8'h00, 8'h80};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    logic         eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, lat);
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL add_latency[%0d]: got %0d cycles expected 8", i, lat);
      end
      total++;
      if (result !== er[i] || carryOut !== ec[i] || overflow !== eo[i]) begin
        bad++;
        $display("FAIL add[%0d] %h+%h: got res=%h co=%b ov=%b expected res=%h co=%b ov=%b",
                 i, va[i], vb[i], result, carryOut, overflow, er[i], ec[i], eo[i]);
      end
      ack_result();
      total++;
      if (startReady !== 1'b1 || resValid !== 1'b0) begin
        bad++;
        $display("FAIL add_return_idle[%0d]: rdy=%b val=%b expected 1 0",
                 i, startReady, resValid);
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va [3] = '{8'h05, 8'h80, 8'h00};
    logic [W-1:0] vb [3] = '{8'h07, 8'h01, 8'h00};
    logic [W-1:0] er [3] = '{8'hFE, 8'h7F, 8'h00};
    logic         ec [3] = '{1'b0, 1'b1, 1'b1};
    logic         eo [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b1, lat);
      total++;
      if (lat !== 8 || result !== er[i] || carryOut !== ec[i] || overflow !== eo[i]) begin
        bad++;
        $display("FAIL sub[%0d] %h-%h: got lat=%0d res=%h co=%b ov=%b expected lat=8 res=%h co=%b ov=%b",
                 i, va[i], vb[i], lat, result, carryOut, overflow, er[i], ec[i], eo[i]);
      end
      ack_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(8'h0F, 8'h01, 1'b0, lat);
    total++;
    if (lat !== 8 || result !== 8'h10) begin
      bad++;
      $display("FAIL bp_setup: got lat=%0d res=%h expected lat=8 res=10", lat, result);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      opA = 8'h33; opB = 8'h44; subtract = 1'b0;
      startValid = (c % 2 == 0);
      @(posedge clk);
      #1;
      total++;
      if (resValid !== 1'b1 || startReady !== 1'b0 || result !== 8'h10 ||
          carryOut !== 1'b0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: val=%b rdy=%b res=%h co=%b ov=%b expected 1 0 10 0 0",
                 c, resValid, startReady, result, carryOut, overflow);
      end
    end
    @(negedge clk);
    startValid = 1'b0;
    resReady = 1'b1;
    @(posedge clk);
    #1;
    resReady = 1'b0;
    total++;
    if (startReady !== 1'b1 || resValid !== 1'b0 || result !== 8'h10) begin
      bad++;
      $display("FAIL bp_release: rdy=%b val=%b res=%h expected 1 0 10",
               startReady, resValid, result);
    end
    run_op(8'h33, 8'h44, 1'b0, lat);
    total++;
    if (lat !== 8 || result !== 8'h77 || carryOut !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_next: got lat=%0d res=%h co=%b ov=%b expected lat=8 res=77 co=0 ov=0",
               lat, result, carryOut, overflow);
    end
    ack_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen = 0;
    @(negedge clk);
    opA = 8'hFF; opB = 8'hFF; subtract = 1'b0; startValid = 1'b1;
    @(posedge clk);
    #1;
    startValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (startReady !== 1'b1 || resValid !== 1'b0 || result !== 8'h00 ||
        carryOut !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: rdy=%b val=%b res=%h co=%b ov=%b expected 1 0 00 0 0",
               startReady, resValid, result, carryOut, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (resValid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_no_valid: got %0d valid cycles expected 0", seen);
    end
    run_op(8'h12, 8'h34, 1'b0, lat);
    total++;
    if (lat !== 8 || result !== 8'h46 || carryOut !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_add: got lat=%0d res=%h co=%b ov=%b expected lat=8 res=46 co=0 ov=0",
               lat, result, carryOut, overflow);
    end
    ack_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
